// File: rtl/ucie_ctl_tx_path.sv
// ucie_ctl_tx_path: FDI-to-RDI transmit path with FWFT FIFO gated by link state request
module ucie_ctl_tx_path #(
    parameter int NBYTES = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_state_request,
    input  logic [NBYTES-1:0]        i_fdi_lp_data,
    input  logic                     i_fdi_lp_valid,
    output logic                     o_fdi_pl_trdy,
    output logic [NBYTES-1:0]        o_rdi_lp_data,
    output logic                     o_rdi_lp_valid,
    input  logic                     i_rdi_pl_trdy,
    output logic                     o_overflow_detected,
    output logic                     o_idle_ack,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       count;
    logic [NBYTES-1:0] mem [DEPTH];
    logic              full, empty, push, pop;

    assign full                = count == (AW+1)'(DEPTH);
    assign empty               = count == '0;
    assign o_fdi_pl_trdy       = state == ACTIVE && !full;
    assign o_rdi_lp_valid      = state != IDLE && !empty;
    assign o_rdi_lp_data       = o_rdi_lp_valid ? mem[rptr] : '0;
    assign o_idle_ack          = state == IDLE;
    assign o_fifo_count        = count;
    assign push                = i_fdi_lp_valid && o_fdi_pl_trdy;
    assign pop                 = o_rdi_lp_valid && i_rdi_pl_trdy;

    // next state: a fresh request always wins over the drain-complete exit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_state_request ? ACTIVE : IDLE;
            ACTIVE:  state_nxt = i_state_request ? ACTIVE : DRAIN;
            DRAIN:   state_nxt = i_state_request ? ACTIVE :
                                 (empty || (pop && count == (AW+1)'(1))) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // state, pointers, count and the one-cycle overflow flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state               <= IDLE;
            wptr                <= '0;
            rptr                <= '0;
            count               <= '0;
            o_overflow_detected <= 1'b0;
        end else begin
            state               <= state_nxt;
            wptr                <= push ? wptr + 1'b1 : wptr;
            rptr                <= pop ? rptr + 1'b1 : rptr;
            count               <= (push && !pop) ? count + 1'b1 :
                                   (pop && !push) ? count - 1'b1 : count;
            o_overflow_detected <= i_fdi_lp_valid && !o_fdi_pl_trdy && state != IDLE;
        end
    end

    // storage is left unreset; stale words are never visible because count gates valid
    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= i_fdi_lp_data;
    end
endmodule

// File: tb/tb_ucie_ctl_tx_path.sv
// tb_ucie_ctl_tx_path: vector table, directed corner sequences and random traffic vs a queue model
module tb_ucie_ctl_tx_path;
    localparam int NBYTES = 32;
    localparam int DEPTH  = 16;
    localparam int M_IDLE = 0, M_ACT = 1, M_DRAIN = 2;

    logic              clk, rst_n, req, fdi_valid, rdi_trdy;
    logic [NBYTES-1:0] fdi_data;
    logic              fdi_trdy, rdi_valid, ovf, idle_ack;
    logic [NBYTES-1:0] rdi_data;
    logic [4:0]        fifo_count;

    ucie_ctl_tx_path #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_state_request(req),
        .i_fdi_lp_data(fdi_data), .i_fdi_lp_valid(fdi_valid), .o_fdi_pl_trdy(fdi_trdy),
        .o_rdi_lp_data(rdi_data), .o_rdi_lp_valid(rdi_valid), .i_rdi_pl_trdy(rdi_trdy),
        .o_overflow_detected(ovf), .o_idle_ack(idle_ack), .o_fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req, v;
        logic [31:0] d;
        logic        rt, e_trdy, e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_cnt;
        logic        e_ovf, e_idle;
    } vec_t;

    vec_t        tbl[7];
    int          checks = 0, errors = 0;
    int          mst;
    logic        movf;
    logic [31:0] q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mst  = M_IDLE;
        movf = 1'b0;
    endtask

    task automatic compare_model();
        logic ev;
        ev = mst != M_IDLE && q.size() > 0;
        chk("trdy", 64'(fdi_trdy), 64'(mst == M_ACT && q.size() < DEPTH));
        chk("valid", 64'(rdi_valid), 64'(ev));
        chk("data", 64'(rdi_data), ev ? 64'(q[0]) : 64'd0);
        chk("ovf", 64'(ovf), 64'(movf));
        chk("idle_ack", 64'(idle_ack), 64'(mst == M_IDLE));
        chk("count", 64'(fifo_count), 64'(q.size()));
    endtask

    task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic rt);
        logic trdy_m, valid_m;
        trdy_m    = mst == M_ACT && q.size() < DEPTH;
        valid_m   = mst != M_IDLE && q.size() > 0;
        req       = r;
        fdi_valid = v;
        fdi_data  = d;
        rdi_trdy  = rt;
        @(posedge clk);
        #1;
        if (valid_m && rt) q.delete(0);
        if (v && trdy_m) q.push_back(d);
        movf = v && !trdy_m && mst != M_IDLE;
        mst  = r ? M_ACT : (mst == M_ACT) ? M_DRAIN : (q.size() == 0) ? M_IDLE : M_DRAIN;
        compare_model();
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d, input logic rt,
                                input logic et, input logic ev, input logic [31:0] ed,
                                input logic [4:0] ec, input logic eo, input logic ei);
        vec_t x;
        x.req = r; x.v = v; x.d = d; x.rt = rt; x.e_trdy = et; x.e_valid = ev;
        x.e_data = ed; x.e_cnt = ec; x.e_ovf = eo; x.e_idle = ei;
        return x;
    endfunction

    initial begin
        tbl[0] = mk(1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 32'hA5, 5'd1, 1'b0, 1'b0);
        tbl[2] = mk(1'b1, 1'b1, 32'h5A, 1'b1, 1'b1, 1'b1, 32'h5A, 5'd1, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 1'b0, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 1'b1, 1'b1);
        tbl[6] = mk(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 1'b0, 1'b1);

        rst_n = 1'b0; req = 1'b0; fdi_valid = 1'b0; fdi_data = '0; rdi_trdy = 1'b0;
        model_reset();
        #12;
        compare_model();
        #5 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].req, tbl[i].v, tbl[i].d, tbl[i].rt);
            chk("tbl_trdy", 64'(fdi_trdy), 64'(tbl[i].e_trdy));
            chk("tbl_valid", 64'(rdi_valid), 64'(tbl[i].e_valid));
            chk("tbl_data", 64'(rdi_data), 64'(tbl[i].e_data));
            chk("tbl_count", 64'(fifo_count), 64'(tbl[i].e_cnt));
            chk("tbl_ovf", 64'(ovf), 64'(tbl[i].e_ovf));
            chk("tbl_idle", 64'(idle_ack), 64'(tbl[i].e_idle));
        end

        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        chk("fill_count", 64'(fifo_count), 64'd16);
        chk("fill_ovf", 64'(ovf), 64'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ovf_single", 64'(ovf), 64'd0);

        for (int i = 0; i < 34; i++) cyc(1'b1, 1'b0, 32'h0, i[0]);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_trdy", 64'(fdi_trdy), 64'd0);
        cyc(1'b0, 1'b1, $urandom, 1'b1);
        chk("drain_ovf", 64'(ovf), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_idle", 64'(idle_ack), 64'd1);

        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("react_left", 64'(fifo_count), 64'd3);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("react_trdy", 64'(fdi_trdy), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, $urandom, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom, 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ucie_ctl_tx_path.md
# ucie_ctl_tx_path

Transmit-direction datapath of the UCIe controller, the counterpart of the RX top. Accepts flits from the protocol layer over the FDI-side handshake, buffers them in a first-word-fall-through FIFO, and presents them to the physical layer over the RDI-side valid/ready handshake. The block is gated by the link state request and drains its buffer in order before reporting idle.

## Interface
- NBYTES, 32: data bus width in bits, for both FDI and RDI data.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous assert, active-low.
- i_state_request  in  1  1 = request Active, 0 = request Idle.
- i_fdi_lp_data  in  NBYTES  protocol-layer data.
- i_fdi_lp_valid  in  1  protocol-layer data valid.
- o_fdi_pl_trdy  out  1  block can accept a beat this cycle.
- o_rdi_lp_data  out  NBYTES  data to the physical layer.
- o_rdi_lp_valid  out  1  o_rdi_lp_data is valid.
- i_rdi_pl_trdy  in  1  physical layer accepts the current beat.
- o_overflow_detected  out  1  one-cycle pulse: a beat was offered while not ready and was dropped.
- o_idle_ack  out  1  block is in IDLE with an empty FIFO.
- o_fifo_count  out  $clog2(DEPTH)+1  current number of FIFO entries.

## Operation
- FSM states are IDLE, ACTIVE and DRAIN. Reset enters IDLE.
- In IDLE:
  - o_fdi_pl_trdy=0 and o_rdi_lp_valid=0.
  - i_state_request=1 moves to ACTIVE on the next edge.
- In ACTIVE:
  - o_fdi_pl_trdy = !full.
  - Push occurs when i_fdi_lp_valid && o_fdi_pl_trdy.
  - o_rdi_lp_valid = !empty, and o_rdi_lp_data is the FIFO head.
  - Pop occurs when o_rdi_lp_valid && i_rdi_pl_trdy.
  - i_state_request=0 moves to DRAIN.
- In DRAIN:
  - o_fdi_pl_trdy=0, and popping continues as in ACTIVE.
  - When the FIFO is empty, or becomes empty at this edge through its last pop, move to IDLE.
  - i_state_request=1 returns to ACTIVE; this has priority over the empty exit.
- Overflow: on any edge where i_fdi_lp_valid=1 and o_fdi_pl_trdy=0 in ACTIVE or DRAIN, the beat is discarded and o_overflow_detected=1 for the following cycle only. Valid presented in IDLE is ignored and raises no flag.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately.
  - full = (count==DEPTH); empty = (count==0).
  - Simultaneous push and pop leaves the count unchanged.
  - Push is never allowed when full, even if a pop happens in the same cycle. This trades one beat of throughput for a registered-only ready.
- Output stability: while o_rdi_lp_valid=1 and i_rdi_pl_trdy=0, o_rdi_lp_data and o_rdi_lp_valid hold unchanged.
- o_rdi_lp_data is forced to 0 whenever o_rdi_lp_valid=0.
- o_idle_ack = (state==IDLE).
- Order is strictly preserved; the block never drops or duplicates an accepted beat.

## Timing
- Reset values:
  - State IDLE; pointers 0; count 0.
  - o_fdi_pl_trdy=0, o_rdi_lp_valid=0, o_rdi_lp_data=0, o_overflow_detected=0, o_fifo_count=0, o_idle_ack=1.
  - FIFO storage is not reset.
- Reset mid-operation: the FIFO is flushed and its contents are lost. Outputs take their reset values asynchronously.
- o_fdi_pl_trdy and o_rdi_lp_valid are decoded from registered state and count only, with no combinational path from i_fdi_lp_valid or i_rdi_pl_trdy.
- Latencies:
  - State request to trdy: i_state_request rising before edge E gives o_fdi_pl_trdy=1 after E.
  - Input to output: a beat pushed at edge N appears on o_rdi_lp_valid/o_rdi_lp_data after edge N (1-cycle latency).
  - Sustained throughput with i_rdi_pl_trdy=1 is 1 beat/cycle.
- IDLE is reached on the edge of the final pop in DRAIN. o_idle_ack rises the cycle after that pop.

## Test plan
- Basic transfer:
  - Stimulus: reset low then high; i_state_request=1; push 0xA5 then 0x5A with i_rdi_pl_trdy=1.
  - Response: o_rdi_lp_valid high for exactly 2 cycles with 0xA5 then 0x5A, each 1 cycle after its push; o_fifo_count never exceeds 1.
- Fill and overflow:
  - Stimulus: i_rdi_pl_trdy=0; offer 17 random beats back-to-back.
  - Response: 16 accepted; o_fdi_pl_trdy drops once o_fifo_count=16; the 17th beat gives a single-cycle o_overflow_detected pulse; count stays 16.
- Backpressure hold and order:
  - Stimulus: with FIFO full, toggle i_rdi_pl_trdy on alternate cycles.
  - Response: output data is stable while stalled; all 16 beats emerge in push order; pointers wrap correctly on a second fill.
- Drain:
  - Stimulus: with 5 entries queued, drop i_state_request and hold i_rdi_pl_trdy=1.
  - Response: o_fdi_pl_trdy=0 immediately after the edge; 5 beats emerge; IDLE is entered on the fifth pop; o_idle_ack=1 the cycle after; a valid offered during DRAIN pulses overflow.
- Re-activate during DRAIN:
  - Stimulus: raise i_state_request with 3 entries left.
  - Response: returns to ACTIVE; accepts new beats after the edge; old entries precede new ones.
- Async reset mid-burst:
  - Stimulus: assert i_rst low between clock edges with 8 entries queued.
  - Response: all outputs are at reset values immediately; after release, no stale data appears.
